wall_scroller: RTL



---
 rtl/wall_defs.sv | 19 +
 rtl/wall_hit_check.sv | 34 +++
 rtl/wall_scroller.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/wall_defs.sv
// wall_defs: shared wall/screen constants and scroller FSM encoding.
// Used by the scroller, renderer and height generator.
package wall_defs;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MOVE,
    S_SPAWN,
    S_CHECK
  } state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int GAP      = 40;
  localparam int WALL_W   = 8;
  localparam int BIRD_X   = 20;
  localparam int BIRD_H   = 4;

endpackage

// File: rtl/wall_hit_check.sv
// wall_hit_check: combinational bird-vs-wall overlap test for one slot.
// All sums are 9 bits so nothing wraps.
module wall_hit_check #(
  parameter int WALL_W = 8,
  parameter int GAP    = 40,
  parameter int BIRD_X = 20,
  parameter int BIRD_H = 4
) (
  input  logic       valid,
  input  logic [7:0] x,
  input  logic [7:0] gap_top,
  input  logic [6:0] bird_y,
  output logic       hit
);

  logic [8:0] x_end;
  logic [8:0] gap_end;
  logic [8:0] by;
  logic [8:0] by_end;
  logic [8:0] bx;
  logic       in_col;
  logic       out_gap;

  assign bx      = 9'(BIRD_X);
  assign x_end   = {1'b0, x} + 9'(WALL_W);
  assign gap_end = {1'b0, gap_top} + 9'(GAP);
  assign by      = {2'b00, bird_y};
  assign by_end  = by + 9'(BIRD_H);

  assign in_col  = ({1'b0, x} <= bx) && (bx < x_end);
  assign out_gap = (by < {1'b0, gap_top}) || (by_end > gap_end);
  assign hit     = valid && in_col && out_gap;

endmodule

// File: rtl/wall_scroller.sv
// wall_scroller: wall slot store; per frame moves each slot, spawns
// a new wall every SPAWN_INTERVAL frames, then checks collision.
module wall_scroller #(
  parameter int MAX_WALLS      = 4,
  parameter int SCREEN_W       = wall_defs::SCREEN_W,
  parameter int SCREEN_H       = wall_defs::SCREEN_H,
  parameter int WALL_W         = wall_defs::WALL_W,
  parameter int GAP            = wall_defs::GAP,
  parameter int SPEED          = 1,
  parameter int SPAWN_INTERVAL = 40,
  parameter int BIRD_X         = wall_defs::BIRD_X,
  parameter int BIRD_H         = wall_defs::BIRD_H
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic                         frame_tick,
  input  logic [7:0]                   height_in,
  input  logic [6:0]                   bird_y,
  input  logic [$clog2(MAX_WALLS)-1:0] rd_idx,
  output logic                         rd_valid,
  output logic [7:0]                   rd_x,
  output logic [7:0]                   rd_gap_top,
  output logic                         busy,
  output logic                         collision,
  output logic [7:0]                   score
);

  import wall_defs::*;

  localparam int IW = $clog2(MAX_WALLS);

  state_t          state, state_d;
  logic [IW-1:0]   idx;
  logic [15:0]     frm;
  logic            v_q [MAX_WALLS];
  logic [7:0]      x_q [MAX_WALLS];
  logic [7:0]      g_q [MAX_WALLS];

  logic [7:0]      cur_x;
  logic [7:0]      new_x;
  logic [8:0]      old_end;
  logic [8:0]      new_end;
  logic            freed;
  logic            passed;
  logic            free_found;
  logic [IW-1:0]   free_idx;
  logic [7:0]      g_new;
  logic [MAX_WALLS-1:0] hit_vec;

  assign busy       = (state != S_IDLE);
  assign rd_valid   = v_q[rd_idx];
  assign rd_x       = x_q[rd_idx];
  assign rd_gap_top = g_q[rd_idx];

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:  if (frame_tick && enable && !collision) state_d = S_MOVE;
      S_MOVE:  if (idx == IW'(MAX_WALLS - 1)) state_d = S_SPAWN;
      S_SPAWN: state_d = S_CHECK;
      S_CHECK: state_d = S_IDLE;
    endcase
  end

  assign cur_x   = x_q[idx];
  assign new_x   = cur_x - 8'(SPEED);
  assign old_end = {1'b0, cur_x} + 9'(WALL_W);
  assign new_end = {1'b0, new_x} + 9'(WALL_W);
  assign freed   = cur_x < 8'(SPEED);
  assign passed  = v_q[idx] && !freed &&
                   (old_end > 9'(BIRD_X)) && (new_end <= 9'(BIRD_X));

  // Lowest-index free slot wins, so scan from the top down.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = MAX_WALLS - 1; i >= 0; i--) begin
      if (!v_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  assign g_new = (height_in > 8'(SCREEN_H - GAP)) ?
                 8'(SCREEN_H - GAP) : height_in;

  for (genvar g = 0; g < MAX_WALLS; g++) begin : g_hit
    wall_hit_check #(
      .WALL_W (WALL_W),
      .GAP    (GAP),
      .BIRD_X (BIRD_X),
      .BIRD_H (BIRD_H)
    ) u_hit (
      .valid   (v_q[g]),
      .x       (x_q[g]),
      .gap_top (g_q[g]),
      .bird_y  (bird_y),
      .hit     (hit_vec[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      idx       <= '0;
      frm       <= '0;
      score     <= '0;
      collision <= 1'b0;
      for (int i = 0; i < MAX_WALLS; i++) begin
        v_q[i] <= 1'b0;
        x_q[i] <= '0;
        g_q[i] <= '0;
      end
    end else begin
      state <= state_d;
      unique case (state)
        S_IDLE: idx <= '0;
        S_MOVE: begin
          idx <= idx + 1'b1;
          if (v_q[idx]) begin
            if (freed) v_q[idx] <= 1'b0;
            else       x_q[idx] <= new_x;
          end
          if (passed && score != 8'hFF) score <= score + 8'd1;
        end
        S_SPAWN: begin
          if (frm == 16'(SPAWN_INTERVAL - 1)) begin
            frm <= '0;
            if (free_found) begin
              v_q[free_idx] <= 1'b1;
              x_q[free_idx] <= 8'(SCREEN_W);
              g_q[free_idx] <= g_new;
            end
          end else begin
            frm <= frm + 16'd1;
          end
        end
        S_CHECK: if (|hit_vec) collision <= 1'b1;
      endcase
    end
  end

endmodule
